aes_mixcol_engine: RTL



---
 rtl/aes_pkg.sv | 17 +
 rtl/aes_mixcol_column.sv | 18 +
 rtl/aes_mixcol_engine.sv | 72 +++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared GF(2^8) helpers, column type and FSM states for the MixColumns engine
package aes_pkg;
  localparam logic [7:0] AES_POLY_RED = 8'h1B;
  typedef logic [31:0] aes_col_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY_RED : 8'h00);
  endfunction
  // k is one of 1, 2, 3, 9, 0B, 0D, 0E; product assembled from the xtime chain a, 2a, 4a, 8a
  function automatic logic [7:0] gmul_const(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction
endpackage

// File: rtl/aes_mixcol_column.sv
// aes_mixcol_column: combinational MixColumns / InvMixColumns of one 32-bit column
module aes_mixcol_column
  import aes_pkg::*;
(
  input  aes_col_t col_i,
  input  logic     inv_i,
  output aes_col_t col_o
);
  logic [15:0] coef;
  // circulant first row, one nibble per coefficient; row r rotates it right by r
  assign coef = inv_i ? 16'hEBD9 : 16'h2311;
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign col_o[31-8*r -: 8] = gmul_const(col_i[31:24], coef[15-4*((4-r)%4) -: 4])
                              ^ gmul_const(col_i[23:16], coef[15-4*((5-r)%4) -: 4])
                              ^ gmul_const(col_i[15:8],  coef[15-4*((6-r)%4) -: 4])
                              ^ gmul_const(col_i[7:0],   coef[15-4*((7-r)%4) -: 4]);
  end
endmodule

// File: rtl/aes_mixcol_engine.sv
// aes_mixcol_engine: handshaked sequential MixColumns / InvMixColumns, COLS_PER_CYCLE columns per cycle
module aes_mixcol_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int NUM_COLS       = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);
  if ((COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) || NUM_COLS != 4) begin : g_bad_cfg
    $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4 and NUM_COLS must be 4");
  end
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);
  state_e     state_q, state_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic       inv_q, inv_d;
  aes_col_t   work_q [4];
  aes_col_t   work_d [4];
  aes_col_t   col_in  [COLS_PER_CYCLE];
  aes_col_t   col_out [COLS_PER_CYCLE];
  logic [1:0] idx     [COLS_PER_CYCLE];
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign idx[g]    = col_idx_q + 2'(g);
    assign col_in[g] = work_q[idx[g]];
    aes_mixcol_column u_col (.col_i(col_in[g]), .inv_i(inv_q), .col_o(col_out[g]));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      col_idx_q <= '0;
      inv_q     <= 1'b0;
      work_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      inv_q     <= inv_d;
      work_q    <= work_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE && in_valid)          ? BUSY :
              (state_q == BUSY && col_idx_q == LAST) ? DONE :
              (state_q == DONE && out_ready)         ? IDLE : state_q;
  end
  always_comb begin
    col_idx_d = col_idx_q;
    inv_d     = inv_q;
    work_d    = work_q;
    if (state_q == IDLE && in_valid) begin
      col_idx_d = '0;
      inv_d     = in_inv;
      for (int c = 0; c < 4; c++) work_d[c] = in_state[127-32*c -: 32];
    end else if (state_q == BUSY) begin
      col_idx_d = col_idx_q + STEP;
      for (int g = 0; g < COLS_PER_CYCLE; g++) work_d[idx[g]] = col_out[g];
    end
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    out_state = out_valid ? {work_q[0], work_q[1], work_q[2], work_q[3]} : '0;
  end
endmodule
